// File: rtl/truth_table_pkg.sv
// Shared types, sizes and the binary-to-Gray helper for the truth-table sweeper.
package truth_table_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        STREAM,
        DONE
    } tt_state_e;

    localparam int unsigned TT_DEPTH  = 16;
    localparam int unsigned TT_IDX_W  = 4;
    localparam int unsigned TT_DATA_W = 7;

    function automatic logic [TT_IDX_W-1:0] bin2gray(input logic [TT_IDX_W-1:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

endpackage

// File: rtl/tt_vec_gen.sv
// Step counter and step-to-vector mapping for the sweeper.
// TRUTH_TABLE_SWEEPER_GRAY_ORDER_EN selects reflected Gray order instead of binary order.
module tt_vec_gen
    import truth_table_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clear,
    input  logic                i_advance,
    output logic [TT_IDX_W-1:0] o_vec,
    output logic                o_last
);

    logic [TT_IDX_W-1:0] r_step;

    // Step holds at its final value after a sweep so the last vector stays applied.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_step <= '0;
        end else if (i_clear) begin
            r_step <= '0;
        end else if (i_advance && !o_last) begin
            r_step <= r_step + TT_IDX_W'(1);
        end
    end

    assign o_last = (r_step == TT_IDX_W'(TT_DEPTH - 1));

`ifdef TRUTH_TABLE_SWEEPER_GRAY_ORDER_EN
    assign o_vec = bin2gray(r_step);
`else
    assign o_vec = r_step;
`endif

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a 4-input function through all vectors, captures its outputs, streams the table.
// Vector order is set by TRUTH_TABLE_SWEEPER_GRAY_ORDER_EN (see tt_vec_gen).
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_IN        = 4,
    parameter int unsigned NUM_OUT       = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [NUM_IN-1:0]    o_vec_out,
    input  logic [NUM_OUT-1:0]   i_func_in,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic [TT_DATA_W-1:0] o_rd_data
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    tt_state_e           r_state, w_state_next;
    logic [3:0]          r_settle, w_settle_next;
    logic [TT_IDX_W-1:0] r_idx, w_idx_next;
    logic                w_clear, w_advance, w_capture, w_last;
    logic [TT_IDX_W-1:0] w_vec;
    logic [NUM_OUT-1:0]  r_table [TT_DEPTH];

    tt_vec_gen u_vec_gen (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_vec     (w_vec),
        .o_last    (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_settle <= '0;
            r_idx    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_settle <= w_settle_next;
            r_idx    <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle;
        w_idx_next    = r_idx;
        w_clear       = 1'b0;
        w_advance     = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next  = DRIVE;
                    w_settle_next = SETTLE_LOAD;
                    w_clear       = 1'b1;
                end
            end
            DRIVE: begin
                if (r_settle == 4'd0) begin
                    w_capture = 1'b1;
                    if (!w_last) begin
                        w_advance     = 1'b1;
                        w_settle_next = SETTLE_LOAD;
                    end else begin
                        w_state_next = STREAM;
                        w_idx_next   = '0;
                    end
                end else begin
                    w_settle_next = r_settle - 4'd1;
                end
            end
            STREAM: begin
                if (i_rd_ready) begin
                    if (r_idx == TT_IDX_W'(TT_DEPTH - 1)) begin
                        w_state_next = DONE;
                    end else begin
                        w_idx_next = r_idx + TT_IDX_W'(1);
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Indexed by the applied vector, so the stored table is order-independent.
    always_ff @(posedge i_clk) begin
        if (w_capture && !i_rst) begin
            r_table[w_vec] <= i_func_in;
        end
    end

    assign o_busy     = (r_state == DRIVE) || (r_state == STREAM);
    assign o_done     = (r_state == DONE);
    assign o_rd_valid = (r_state == STREAM);
    assign o_rd_data  = o_rd_valid ? {r_idx, r_table[r_idx]} : '0;
    assign o_vec_out  = w_vec;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper against a cycle-count model of a sweep.
module tb_truth_table_sweeper;

    localparam int unsigned S = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rd_ready = 1'b1;
    logic       busy, done, rd_valid;
    logic [3:0] vec;
    logic [2:0] func;
    logic [6:0] rd_data;

    logic       start2 = 1'b0;
    logic       ready2 = 1'b1;
    logic       busy2, done2, valid2;
    logic [3:0] vec2;
    logic [2:0] func2;
    logic [6:0] data2;

    truth_table_sweeper #(.SETTLE_CYCLES(S), .NUM_IN(4), .NUM_OUT(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
        .o_vec_out(vec), .i_func_in(func), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
        .o_rd_data(rd_data)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1), .NUM_IN(4), .NUM_OUT(3)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .o_busy(busy2), .o_done(done2),
        .o_vec_out(vec2), .i_func_in(func2), .o_rd_valid(valid2), .i_rd_ready(ready2),
        .o_rd_data(data2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Function under test: 0 loopback, 1 constant 110, 2 random table, 3 delayed loopback
    int         mode = 0;
    int         rdy_mode = 0;
    logic [2:0] rtbl [16];
    logic [2:0] dly = 3'b000;
    logic [3:0] order [16];
    logic [2:0] exp_tbl [16];
    logic [2:0] exp2 [16];

    always @(posedge clk) dly <= vec[2:0];
    always @(posedge clk) func2 <= vec2[2:0];

    always_comb begin
        func = vec[2:0];
        case (mode)
            1: func = 3'b110;
            2: func = rtbl[vec];
            3: func = dly;
            default: func = vec[2:0];
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: phase 0 idle, 1 sweeping, 2 streaming, 3 done; position from elapsed cycles.
    int         m_ph = 0, m_k = 0, m_beat = 0;
    logic [3:0] m_vec = 4'h0;
    always @(posedge clk) begin
        if (rst) begin
            m_ph <= 0; m_k <= 0; m_beat <= 0; m_vec <= 4'h0;
        end else begin
            case (m_ph)
                0: if (start) begin m_ph <= 1; m_k <= 0; m_vec <= order[0]; end
                1: if (m_k == 16 * S - 1) begin
                       m_ph <= 2; m_beat <= 0;
                   end else begin
                       m_k <= m_k + 1; m_vec <= order[(m_k + 1) / S];
                   end
                2: if (rd_ready) begin
                       if (m_beat == 15) m_ph <= 3;
                       else m_beat <= m_beat + 1;
                   end
                default: m_ph <= 0;
            endcase
        end
    end

    bit         chk_en = 1'b0;
    logic [6:0] q [$];
    logic [6:0] q2 [$];
    int         t_first = 0, t0 = 0, n_done = 0, done_base = 0;
    bit         stall_prev = 1'b0;
    logic [6:0] stall_data = '0;
    logic [3:0] prev_vec = 4'h0;
    bit         prev_sweep = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, (m_ph == 1) || (m_ph == 2));
            chk("done", done, m_ph == 3);
            chk("rd_valid", rd_valid, m_ph == 2);
            chk("vec_out", vec, m_vec);
            if (m_ph == 2) chk("rd_data", rd_data, {m_beat[3:0], exp_tbl[m_beat]});
            if (rd_valid && stall_prev) chk("stall_hold", rd_data, stall_data);
            stall_prev = rd_valid && !rd_ready;
            stall_data = rd_data;
            if (rd_valid && rd_ready) begin
                if (q.size() == 0) t_first = cyc;
                q.push_back(rd_data);
            end
            if (done) n_done++;
`ifdef TRUTH_TABLE_SWEEPER_GRAY_ORDER_EN
            if (prev_sweep && busy && !rd_valid && vec != prev_vec)
                chk("gray_hamming", $countones(vec ^ prev_vec), 1);
`endif
            prev_sweep = busy && !rd_valid;
            prev_vec   = vec;
            if (valid2) q2.push_back(data2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: rd_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2: rd_ready = 1'($urandom_range(0, 1));
                default: rd_ready = 1'b1;
            endcase
        end
    end

    task automatic begin_sweep(input int fmode, input int rmode);
        mode = fmode;
        rdy_mode = rmode;
        for (int i = 0; i < 16; i++) begin
            rtbl[i] = 3'($urandom_range(0, 7));
            case (fmode)
                1: exp_tbl[i] = 3'b110;
                2: exp_tbl[i] = rtbl[i];
                default: exp_tbl[i] = i[2:0];
            endcase
        end
        q.delete();
        done_base = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_vec(input logic [3:0] target);
        int n = 0;
        while (vec !== target && n < 200) begin tick(); n++; end
        chk("reach_vec", vec, target);
    endtask

    task automatic finish_sweep(input bit poke_done);
        int n = 0;
        while (!done && n < 2000) begin tick(); n++; end
        chk("done_seen", done, 1'b1);
        if (poke_done) start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("busy_after", busy, 1'b0);
        chk("done_once", n_done - done_base, 1);
        chk("beats", q.size(), 16);
        for (int k = 0; k < 16 && k < q.size(); k++) chk("beat_idx", q[k][6:3], k);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
`ifdef TRUTH_TABLE_SWEEPER_GRAY_ORDER_EN
            order[i] = 4'(i ^ (i >> 1));
`else
            order[i] = 4'(i);
`endif
        end
        for (int s = 0; s < 16; s++) begin
            logic [3:0] pv;
            pv = (s == 0) ? 4'h0 : order[s - 1];
            exp2[order[s]] = pv[2:0];
        end

        repeat (3) tick();
        chk_en = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_data", rd_data, 7'h00);
        chk("rst_vec", vec, 4'h0);
        rst = 1'b0;
        repeat (2) tick();

        // Loopback, always ready
        begin_sweep(0, 0);
        finish_sweep(1'b0);
        chk("first_beat_latency", t_first - t0, 32);
        if (q.size() > 5) chk("beat5_literal", q[5], 7'b0101_101);

        // Constant function with 1,0,0,1 ready pattern
        begin_sweep(1, 1);
        finish_sweep(1'b0);
        for (int k = 0; k < 16 && k < q.size(); k++) chk("const_low", q[k][2:0], 3'b110);

        // Random table, random ready, start during step 7 and during DONE
        begin_sweep(2, 2);
        wait_vec(order[7]);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_sweep(1'b1);
        chk("no_restart_busy", busy, 1'b0);

        // Reset at step 9, then a full sweep
        begin_sweep(0, 0);
        wait_vec(order[9]);
        rst = 1'b1;
        tick();
        chk("mid_rst_vec", vec, 4'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", rd_valid, 1'b0);
        rst = 1'b0;
        tick();
        begin_sweep(2, 2);
        finish_sweep(1'b0);

        // Registered one-cycle-late function, settle 2 still captures correctly
        begin_sweep(3, 0);
        finish_sweep(1'b0);

        // Settle 1 with late function: each capture shows the previous vector
        q2.delete();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        begin
            int n = 0;
            while (!done2 && n < 500) begin tick(); n++; end
        end
        chk("dut2_done", done2, 1'b1);
        chk("dut2_beats", q2.size(), 16);
        for (int k = 0; k < 16 && k < q2.size(); k++)
            chk("dut2_entry", q2[k], {4'(k), exp2[k]});

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
